// File: rtl/button_conditioner.sv
// Synchronises and debounces the pause/run and reset buttons, emitting press strobes and the run level.
// Optional long-press clear on the pause/run button: define BUTTON_CONDITIONER_LONG_PRESS_EN.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20,
   parameter int LONG_CYCLES     = 100_000_000,
   parameter int LONG_W          = 27
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_p,
   input  logic btn_r,
   output logic p_level,
   output logic r_level,
   output logic p_pulse,
   output logic clear,
   output logic run
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Channel index 0 is the pause/run button, index 1 the reset button.
   logic [1:0]       raw;
   logic [1:0]       s1;
   logic [1:0]       s2;
   logic [1:0]       stable;
   logic [1:0]       rise;
   logic [CNT_W-1:0] cnt [2];
   logic             long_hit;

   assign raw     = {btn_r, btn_p};
   assign p_level = stable[0];
   assign r_level = stable[1];

   always_comb begin
      rise = '0;
      for (int i = 0; i < 2; i++) begin
         rise[i] = s2[i] & ~stable[i] & (cnt[i] == CNT_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1     <= '0;
         s2     <= '0;
         stable <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               stable[i] <= s2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
   localparam logic [LONG_W-1:0] HOLD_MAX = LONG_W'(LONG_CYCLES);
   localparam logic [LONG_W-1:0] HOLD_HIT = LONG_W'(LONG_CYCLES - 1);

   logic [LONG_W-1:0] hold;

   // Saturates at HOLD_MAX so a single held press clears only once.
   always_ff @(posedge clk) begin
      if (!reset_n || !stable[0]) begin
         hold <= '0;
      end else if (hold != HOLD_MAX) begin
         hold <= hold + 1'b1;
      end
   end

   assign long_hit = stable[0] & (hold == HOLD_HIT);
`else
   logic [LONG_W-1:0] unused_long_cfg;

   assign unused_long_cfg = LONG_W'(LONG_CYCLES);
   assign long_hit        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         p_pulse <= 1'b0;
         clear   <= 1'b0;
         run     <= 1'b0;
      end else begin
         p_pulse <= rise[0];
         clear   <= rise[1] | long_hit;
         if (clear) begin
            run <= 1'b0;
         end else if (p_pulse) begin
            run <= ~run;
         end
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4 and LONG_CYCLES=20.
module tb_button_conditioner;

   logic clk = 1'b0;
   logic reset_n;
   logic btn_p;
   logic btn_r;
   logic p_level;
   logic r_level;
   logic p_pulse;
   logic clear;
   logic run;

   button_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (3),
      .LONG_CYCLES    (20),
      .LONG_W         (5)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .btn_p  (btn_p),
      .btn_r  (btn_r),
      .p_level(p_level),
      .r_level(r_level),
      .p_pulse(p_pulse),
      .clear  (clear),
      .run    (run)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int   at;
      logic p;
      logic c;
      logic run_after;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_strobe(input int dly, input logic p, input logic c, input logic r);
      exp_t e;
      e.at        = cyc + dly;
      e.p         = p;
      e.c         = c;
      e.run_after = r;
      exp_q.push_back(e);
   endtask

   // Monitor: every strobe must match the head of the queue; run is checked one cycle later.
   logic run_pending = 1'b0;
   logic run_req     = 1'b0;
   always @(negedge clk) begin
      if (run_pending) begin
         chk("run_after_strobe", int'(run), int'(run_req));
         run_pending = 1'b0;
      end
      if (p_pulse || clear) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", int'({p_pulse, clear}), 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("strobe_cycle", cyc, e.at);
            chk("strobe_kind", int'({p_pulse, clear}), int'({e.p, e.c}));
            run_pending = 1'b1;
            run_req     = e.run_after;
         end
      end
   end

   int N;
   initial begin
      reset_n = 1'b0;
      btn_p   = 1'b1;
      btn_r   = 1'b1;

      // Reset with both buttons held high
      tick(3);
      chk("rst_p_level", int'(p_level), 0);
      chk("rst_r_level", int'(r_level), 0);
      chk("rst_p_pulse", int'(p_pulse), 0);
      chk("rst_clear",   int'(clear),   0);
      chk("rst_run",     int'(run),     0);
      reset_n = 1'b1;
      expect_strobe(6, 1'b1, 1'b1, 1'b0);
      tick(12);
      btn_p = 1'b0;
      btn_r = 1'b0;
      tick(12);

      // Clean press, then a second press/release back to paused
      btn_p = 1'b1;
      expect_strobe(6, 1'b1, 1'b0, 1'b1);
      tick(10);
      chk("hold_p_level", int'(p_level), 1);
      btn_p = 1'b0;
      tick(10);
      chk("release_p_level", int'(p_level), 0);
      btn_p = 1'b1;
      expect_strobe(6, 1'b1, 1'b0, 1'b0);
      tick(10);
      btn_p = 1'b0;
      tick(12);

      // Bounce: runs of 1..3 cycles must never be accepted
      begin
         int runs [10] = '{1, 2, 3, 1, 2, 3, 3, 2, 1, 2};
         for (int i = 0; i < 10; i++) begin
            btn_p = (i % 2 == 0);
            tick(runs[i]);
         end
      end
      btn_p = 1'b1;
      expect_strobe(6, 1'b1, 1'b0, 1'b1);
      tick(10);
      btn_p = 1'b0;
      tick(12);

      // Simultaneous press with run = 1: clear wins
      chk("pre_simul_run", int'(run), 1);
      btn_p = 1'b1;
      btn_r = 1'b1;
      expect_strobe(6, 1'b1, 1'b1, 1'b0);
      tick(10);
      chk("simul_r_level", int'(r_level), 1);
      btn_p = 1'b0;
      btn_r = 1'b0;
      tick(12);

      // Reset in the middle of the reset-button debounce
      btn_r = 1'b1;
      N = cyc;
      tick(2);
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      chk("mid_reset_cycle", cyc, N + 3);
      expect_strobe(6, 1'b0, 1'b1, 1'b0);
      tick(10);
      btn_r = 1'b0;
      tick(12);

      // Long hold on pause/run
      btn_p = 1'b1;
      expect_strobe(6, 1'b1, 1'b0, 1'b1);
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
      expect_strobe(26, 1'b0, 1'b1, 1'b0);
`endif
      tick(40);
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
      chk("long_run", int'(run), 0);
`else
      chk("long_run", int'(run), 1);
`endif
      btn_p = 1'b0;
      tick(12);

      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
